// File: rtl/rx_block_lock_32b_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_block_lock_32b_if
// Description : Bundles the gearbox-facing sample bus, lock control and
//               status signals of the 32-bit block-lock controller.
//   hdr           2-bit sync header from the gearbox (valid on header words)
//   din_en        word qualifier from the gearbox
//   even          block phase; header word when din_en=1 and even=0
//   lock_en       0 forces hunting and keeps block_lock low
//   slip          one-cycle one-bit slip request to the gearbox
//   block_lock    header alignment achieved
//   dec_en        din_en gated by block_lock, for the downstream decoder
//   lock_loss_cnt saturating count of lock losses
//   master: gearbox/control side, slave: block-lock controller side
// Revision    : 1.0 - initial release
// ============================================================================
interface rx_block_lock_32b_if;
    logic [1:0]  hdr;
    logic        din_en;
    logic        even;
    logic        lock_en;
    logic        slip;
    logic        block_lock;
    logic        dec_en;
    logic [15:0] lock_loss_cnt;

    modport master (
        output hdr, din_en, even, lock_en,
        input  slip, block_lock, dec_en, lock_loss_cnt
    );

    modport slave (
        input  hdr, din_en, even, lock_en,
        output slip, block_lock, dec_en, lock_loss_cnt
    );
endinterface
`default_nettype wire

// File: rtl/rx_block_lock_32b.sv
`default_nettype none
// ============================================================================
// Module      : rx_block_lock_32b
// Description : 64b/66b block-lock controller (10GBASE-R RX, 32-bit words).
//               Counts sync headers, requests gearbox slips while hunting
//               and declares/loses block lock based on header validity.
//   clk  core clock
//   rst  asynchronous active-high reset
//   bus  rx_block_lock_32b_if.slave (hdr/din_en/even/lock_en in,
//        slip/block_lock/dec_en/lock_loss_cnt out)
// Revision    : 1.0 - initial release
// ============================================================================
module rx_block_lock_32b #(
    parameter int LOCK_CNT  = 64,
    parameter int ERR_LIMIT = 16,
    parameter int SLIP_WAIT = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    rx_block_lock_32b_if.slave    bus
);

    localparam int c_SH_W   = $clog2(LOCK_CNT + 1);
    localparam int c_ERR_W  = $clog2(ERR_LIMIT + 1);
    localparam int c_WAIT_W = $clog2(SLIP_WAIT + 1);

    localparam logic [1:0] c_ST_HUNT   = 2'd0;
    localparam logic [1:0] c_ST_SLIP   = 2'd1;
    localparam logic [1:0] c_ST_SWAIT  = 2'd2;
    localparam logic [1:0] c_ST_LOCKED = 2'd3;

    localparam logic [c_SH_W-1:0]   c_SH_MAX   = c_SH_W'(LOCK_CNT);
    localparam logic [c_ERR_W-1:0]  c_ERR_MAX  = c_ERR_W'(ERR_LIMIT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LD  = c_WAIT_W'(SLIP_WAIT);

    logic [1:0]          r_state,   w_state_nxt;
    logic [c_SH_W-1:0]   r_sh_cnt,  w_sh_nxt;
    logic [c_ERR_W-1:0]  r_err_cnt, w_err_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt, w_wait_nxt;

    logic        r_slip,  w_slip_nxt;
    logic        r_block_lock, w_lock_nxt;
    logic [15:0] r_lock_loss_cnt, w_loss_cnt_nxt;

    logic               w_sample;
    logic               w_valid;
    logic [c_SH_W-1:0]  w_sh_inc;
    logic [c_ERR_W-1:0] w_err_inc;

    assign w_sample  = bus.din_en & ~bus.even;
    assign w_valid   = bus.hdr[0] ^ bus.hdr[1];
    assign w_sh_inc  = r_sh_cnt + c_SH_W'(1);
    assign w_err_inc = r_err_cnt + c_ERR_W'(1);

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= c_ST_HUNT;
            r_sh_cnt        <= '0;
            r_err_cnt       <= '0;
            r_wait_cnt      <= '0;
            r_slip          <= 1'b0;
            r_block_lock    <= 1'b0;
            r_lock_loss_cnt <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_sh_cnt        <= w_sh_nxt;
            r_err_cnt       <= w_err_nxt;
            r_wait_cnt      <= w_wait_nxt;
            r_slip          <= w_slip_nxt;
            r_block_lock    <= w_lock_nxt;
            r_lock_loss_cnt <= w_loss_cnt_nxt;
        end
    end

    // Next state and counter updates
    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh_cnt;
        w_err_nxt   = r_err_cnt;
        w_wait_nxt  = r_wait_cnt;
        if (!bus.lock_en) begin
            w_state_nxt = c_ST_HUNT;
            w_sh_nxt    = '0;
            w_err_nxt   = '0;
            w_wait_nxt  = '0;
        end else begin
            case (r_state)
                c_ST_HUNT: begin
                    if (w_sample) begin
                        if (!w_valid) begin
                            w_state_nxt = c_ST_SLIP;
                            w_sh_nxt    = '0;
                            w_err_nxt   = '0;
                        end else if (w_sh_inc == c_SH_MAX) begin
                            w_state_nxt = c_ST_LOCKED;
                            w_sh_nxt    = '0;
                            w_err_nxt   = '0;
                        end else begin
                            w_sh_nxt    = w_sh_inc;
                        end
                    end
                end
                c_ST_SLIP: begin
                    w_state_nxt = c_ST_SWAIT;
                    w_wait_nxt  = c_WAIT_LD;
                end
                c_ST_SWAIT: begin
                    // Headers are ignored while the gearbox settles
                    if (r_wait_cnt == '0) begin
                        w_state_nxt = c_ST_HUNT;
                        w_sh_nxt    = '0;
                        w_err_nxt   = '0;
                    end else begin
                        w_wait_nxt  = r_wait_cnt - c_WAIT_W'(1);
                    end
                end
                default: begin // c_ST_LOCKED
                    if (w_sample) begin
                        // Loss of lock takes priority over window end
                        if (!w_valid && (w_err_inc == c_ERR_MAX)) begin
                            w_state_nxt = c_ST_SLIP;
                            w_sh_nxt    = '0;
                            w_err_nxt   = '0;
                        end else if (w_sh_inc == c_SH_MAX) begin
                            w_sh_nxt    = '0;
                            w_err_nxt   = '0;
                        end else begin
                            w_sh_nxt    = w_sh_inc;
                            w_err_nxt   = w_valid ? r_err_cnt : w_err_inc;
                        end
                    end
                end
            endcase
        end
    end

    // Output decode; lock_en low in SLIP drops the pending pulse
    always_comb begin
        w_slip_nxt     = (r_state == c_ST_SLIP) && bus.lock_en;
        w_lock_nxt     = (w_state_nxt == c_ST_LOCKED);
        w_loss_cnt_nxt = r_lock_loss_cnt;
        if ((r_state == c_ST_LOCKED) && (w_state_nxt == c_ST_SLIP) &&
            (r_lock_loss_cnt != 16'hFFFF)) begin
            w_loss_cnt_nxt = r_lock_loss_cnt + 16'd1;
        end
    end

    assign bus.slip          = r_slip;
    assign bus.block_lock    = r_block_lock;
    assign bus.lock_loss_cnt = r_lock_loss_cnt;
    assign bus.dec_en        = bus.din_en & r_block_lock;

endmodule
`default_nettype wire

// File: doc/rx_block_lock_32b.md
Name: rx_block_lock_32b

Overview:
- 64b/66b block-lock controller for the 10GBASE-R receive path, 32-bit word domain.
- Monitors the 2-bit sync header that accompanies the first 32-bit half of each 66b block.
- Issues slip requests to the upstream gearbox until header alignment is found. Asserts block_lock when aligned.
- Provides a gated data-enable for the downstream 32-bit RX decoder.
- Implements the IEEE 802.3 clause 49 lock state machine in simplified form.

Parameters:
- LOCK_CNT, 64: consecutive valid headers required to declare lock; also the locked-mode window length.
- ERR_LIMIT, 16: invalid headers within one locked window that cause loss of lock.
- SLIP_WAIT, 32: clk cycles the FSM ignores headers after a slip pulse, covering gearbox settle time.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- hdr  in  2  sync header from gearbox; valid only on a header word
- din_en  in  1  word qualifier from gearbox
- even  in  1  block phase; a word is a header word when din_en=1 and even=0
- lock_en  in  1  0 forces HUNT state, suppresses slip, and keeps block_lock low
- slip  out  1  one-cycle pulse requesting a one-bit gearbox slip
- block_lock  out  1  alignment achieved
- dec_en  out  1  din_en & block_lock (combinational), drives decoder din_en
- lock_loss_cnt  out  16  saturating count of LOCKED->unlocked transitions

Behaviour:
- Reset (async, rst=1):
  - state=HUNT; all counters 0.
  - slip=0, block_lock=0, lock_loss_cnt=0.
- Header sample: a cycle with din_en=1 & even=0.
  - A sample is valid when hdr[0]!=hdr[1], i.e. 2'b01 or 2'b10.
  - Any other cycle is not a sample and changes no counter.
- Counters:
  - sh_cnt: width $clog2(LOCK_CNT+1).
  - err_cnt: width $clog2(ERR_LIMIT+1).
  - wait_cnt: width $clog2(SLIP_WAIT+1).
- HUNT:
  - Valid sample: sh_cnt++.
  - Invalid sample: go to SLIP.
  - Valid sample that brings sh_cnt to LOCK_CNT: go to LOCKED, clear sh_cnt and err_cnt, block_lock=1 from the next cycle.
- SLIP:
  - slip=1 for exactly one cycle, the cycle after SLIP is entered.
  - wait_cnt loads SLIP_WAIT.
  - Then go to SWAIT.
- SWAIT:
  - wait_cnt decrements each clk; header samples are ignored.
  - At 0: go to HUNT with sh_cnt=0 and err_cnt=0.
- LOCKED:
  - Every sample: sh_cnt++. An invalid sample also does err_cnt++.
  - Invalid sample that brings err_cnt to ERR_LIMIT: on the next cycle block_lock=0, lock_loss_cnt++ (saturates at 16'hFFFF), and the FSM goes to SLIP.
  - Sample that brings sh_cnt to LOCK_CNT without reaching ERR_LIMIT: clear sh_cnt and err_cnt, stay LOCKED.
  - Simultaneous window end and ERR_LIMIT reached on the same sample: loss of lock wins.
- lock_en=0:
  - Synchronous to clk; from any state, go to HUNT next cycle with counters cleared.
  - block_lock=0; slip is not issued.
  - lock_loss_cnt is held, not incremented.
  - If lock_en=0 in the same cycle a slip would start, the slip is suppressed.
- Pulse spacing: slip pulses are separated by at least SLIP_WAIT+2 cycles.
- All outputs except dec_en are registered.
- Reset asserted mid-operation: outputs clear immediately (asynchronous); a pending slip is dropped.

Test Plan:
- Lock acquisition: rst released, lock_en=1, 64 header samples with hdr=2'b01 on alternating words (even toggling, din_en=1). block_lock rises the cycle after the 64th sample; slip never pulses.
- Hunt slip: in HUNT after 10 valid samples, one sample with hdr=2'b11. slip pulses exactly once. No sample is counted for 32 cycles. The next 64 valid samples then lock.
- Tolerated errors: locked, one window of 64 samples containing 15 invalid (2'b00). block_lock stays 1 and lock_loss_cnt stays 0. The next window starts with err_cnt=0.
- Loss of lock: locked, 16 invalid samples within one window. block_lock falls the cycle after the 16th. slip pulses once. lock_loss_cnt goes 0->1.
- Non-header words: hdr=2'b11 on words with even=1, and on words with din_en=0. No effect; lock is still reached after 64 valid samples.
- Control override: lock_en dropped while locked → block_lock=0 next cycle, no slip, lock_loss_cnt unchanged. rst asserted mid-SWAIT → all outputs 0 immediately; HUNT on release.
